// File: rtl/axis_spi_slave_mode.sv
// axis_spi_slave_mode
//   SPI slave that bridges an external SPI master to AXI-Stream in the aclk
//   domain. The CPOL/CPHA mode, bit order, word width, TX FIFO depth and the
//   word sent when the FIFO is empty are all parameters. SCK is oversampled,
//   so aclk must run at least 8x SCK. No logic runs on SCK.
//
// Ports
//   aclk, aresetn          system clock, asynchronous active-low reset
//   SS_I, SCK_I, IO0_I     SPI pins from the master (slave select, clock, MOSI)
//   IO1_O, IO1_T           MISO data and tristate enable (1 = high-Z)
//   axis_rx_*              received words; tuser marks the first word of a frame
//   axis_tx_*              words to transmit, buffered in the TX FIFO
//   frame_active           a frame is in progress (synchronised SS low)
//   tx_underrun            pulse: a word load found the TX FIFO empty
//   rx_overflow            pulse: a completed word was dropped
//   rx_partial             pulse: SS rose with a partial word received
module axis_spi_slave_mode #(
  parameter int unsigned C_DATA_WIDTH    = 8,
  parameter int unsigned C_CPOL          = 0,
  parameter int unsigned C_CPHA          = 1,
  parameter int unsigned C_LSB_FIRST     = 0,
  parameter int unsigned C_TX_FIFO_DEPTH = 4,
  parameter int unsigned C_IDLE_WORD     = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    SS_I,
  input  logic                    SCK_I,
  input  logic                    IO0_I,
  output logic                    IO1_O,
  output logic                    IO1_T,
  output logic [C_DATA_WIDTH-1:0] axis_rx_tdata,
  output logic                    axis_rx_tuser,
  output logic                    axis_rx_tvalid,
  input  logic                    axis_rx_tready,
  input  logic [C_DATA_WIDTH-1:0] axis_tx_tdata,
  input  logic                    axis_tx_tvalid,
  output logic                    axis_tx_tready,
  output logic                    frame_active,
  output logic                    tx_underrun,
  output logic                    rx_overflow,
  output logic                    rx_partial
);

  localparam int unsigned W  = C_DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned AW = $clog2(C_TX_FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_BIT  = CW'(W - 1);
  localparam logic [W-1:0]  IDLE_WORD = W'(C_IDLE_WORD);
  localparam logic          CPOL      = C_CPOL[0];
  localparam logic          CPHA      = C_CPHA[0];
  localparam logic          LSB       = C_LSB_FIRST[0];

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // Synchronisers and edge detection
  logic [1:0] ss_sync;
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic       ss_d;
  logic       sck_d;

  // SS history resets to 'low' so an SS held low across reset is not taken
  // as a new frame start; the block waits for SS to rise and fall again.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ss_sync   <= '0;
      ss_d      <= 1'b0;
      sck_sync  <= {2{CPOL}};
      sck_d     <= CPOL;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[0], SS_I};
      ss_d      <= ss_sync[1];
      sck_sync  <= {sck_sync[0], SCK_I};
      sck_d     <= sck_sync[1];
      mosi_sync <= {mosi_sync[0], IO0_I};
    end
  end

  logic ss_fall, ss_rise;
  logic sck_lead, sck_trail;
  logic sample_edge, shift_edge;

  assign ss_fall     = ss_d & ~ss_sync[1];
  assign ss_rise     = ~ss_d & ss_sync[1];
  assign sck_lead    = (sck_d == CPOL) && (sck_sync[1] != CPOL);
  assign sck_trail   = (sck_d != CPOL) && (sck_sync[1] == CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;

  // TX FIFO (extra pointer MSB distinguishes full from empty)
  logic [W-1:0] fifo_mem [C_TX_FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_empty, fifo_full, push, pop;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign axis_tx_tready = ~fifo_full;
  assign push           = axis_tx_tvalid & ~fifo_full;

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= axis_tx_tdata;
  end

  // Datapath control
  logic [0:0]    state;
  logic [CW-1:0] bit_cnt;
  logic          first_word;
  logic [W-1:0]  rx_sr, tx_sr;
  logic [W-1:0]  rx_next, tx_adv, load_word;
  logic          word_load, do_shift, sample, word_done, rx_accept;

  function automatic logic out_bit(input logic [W-1:0] v);
    return LSB ? v[0] : v[W-1];
  endfunction

  // A word is loaded on the first shift edge of each word (bit count 0);
  // with CPHA=0 the first word must already be on MISO before the first
  // sample edge, so it is loaded at SS fall instead.
  always_comb begin
    word_load = 1'b0;
    if (state == S_IDLE) word_load = ss_fall && !CPHA;
    else                 word_load = !ss_rise && shift_edge && (bit_cnt == '0);
  end

  assign do_shift  = (state == S_ACTIVE) && !ss_rise && shift_edge && !word_load;
  assign sample    = (state == S_ACTIVE) && !ss_rise && sample_edge;
  assign word_done = sample && (bit_cnt == LAST_BIT);
  assign rx_accept = !axis_rx_tvalid || axis_rx_tready;
  assign pop       = word_load & ~fifo_empty;
  assign load_word = fifo_empty ? IDLE_WORD : fifo_mem[rd_ptr[AW-1:0]];
  assign rx_next   = LSB ? {mosi_sync[1], rx_sr[W-1:1]} : {rx_sr[W-2:0], mosi_sync[1]};
  assign tx_adv    = LSB ? (tx_sr >> 1) : (tx_sr << 1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      first_word     <= 1'b0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      IO1_O          <= 1'b0;
      IO1_T          <= 1'b1;
      frame_active   <= 1'b0;
      tx_underrun    <= 1'b0;
      rx_overflow    <= 1'b0;
      rx_partial     <= 1'b0;
      axis_rx_tdata  <= '0;
      axis_rx_tuser  <= 1'b0;
      axis_rx_tvalid <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      tx_underrun <= word_load & fifo_empty;
      rx_overflow <= word_done & ~rx_accept;
      rx_partial  <= (state == S_ACTIVE) & ss_rise & (bit_cnt != '0);

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (word_load) begin
        tx_sr <= load_word;
        IO1_O <= out_bit(load_word);
      end else if (do_shift) begin
        tx_sr <= tx_adv;
        IO1_O <= out_bit(tx_adv);
      end

      if (state == S_IDLE) begin
        if (ss_fall) begin
          state        <= S_ACTIVE;
          bit_cnt      <= '0;
          first_word   <= 1'b1;
          IO1_T        <= 1'b0;
          frame_active <= 1'b1;
        end
      end else begin
        if (ss_rise) begin
          // SS rise has priority over a sample edge in the same cycle
          state        <= S_IDLE;
          bit_cnt      <= '0;
          IO1_T        <= 1'b1;
          frame_active <= 1'b0;
        end else if (sample) begin
          rx_sr   <= rx_next;
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
      end

      if (word_done && rx_accept) begin
        axis_rx_tdata  <= rx_next;
        axis_rx_tuser  <= first_word;
        axis_rx_tvalid <= 1'b1;
        first_word     <= 1'b0;
      end else if (axis_rx_tvalid && axis_rx_tready) begin
        axis_rx_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_spi_slave_mode.md
Name: axis_spi_slave_mode

Overview:
- Parametrised successor to the fixed-mode AXI-Stream SPI slave.
- Supports all four CPOL/CPHA modes, selectable MSB/LSB-first, any word width, and a configurable-depth TX FIFO.
- Received words carry a frame-start flag; the block reports underrun, overflow and partial-word events.
- Sits between an external SPI master (pins) and AXI-Stream logic in the aclk domain. SCK is oversampled; no SCK-clocked logic.

Parameters:
- C_DATA_WIDTH, 8: word width in bits, legal range 4..32.
- C_CPOL, 0: SCK idle level.
- C_CPHA, 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- C_LSB_FIRST, 0: 1 = shift LSB first on both MOSI and MISO.
- C_TX_FIFO_DEPTH, 4: TX FIFO entries; power of 2, minimum 2.
- C_IDLE_WORD, 0: word shifted out on MISO when the TX FIFO is empty at a word load.

Ports:
- aclk  in  1  system clock; must be at least 8x SCK.
- aresetn  in  1  reset, asynchronous, active-low.
- SS_I  in  1  slave select, active-low, asynchronous to aclk.
- SCK_I  in  1  SPI clock, asynchronous to aclk.
- IO0_I  in  1  MOSI.
- IO1_O  out  1  MISO data.
- IO1_T  out  1  MISO tristate enable; 1 = high-Z.
- axis_rx_tdata  out  C_DATA_WIDTH  received word.
- axis_rx_tuser  out  1  1 = first word of the frame.
- axis_rx_tvalid  out  1  RX valid.
- axis_rx_tready  in  1  RX ready.
- axis_tx_tdata  in  C_DATA_WIDTH  word to transmit.
- axis_tx_tvalid  in  1  TX valid.
- axis_tx_tready  out  1  TX ready; equals FIFO not full.
- frame_active  out  1  synchronised SS is low.
- tx_underrun  out  1  1-cycle pulse: word load found the FIFO empty.
- rx_overflow  out  1  1-cycle pulse: completed word dropped.
- rx_partial  out  1  1-cycle pulse: SS rose with bit count not 0.

Behaviour:
- Synchronisation and edges:
  - SS_I, SCK_I and IO0_I each pass through a 2-FF synchroniser.
  - SCK edges are detected on the synchronised copy: detection cycle = 2-3 aclk after the pin edge.
  - Leading edge = transition away from C_CPOL.
  - Sample edge = leading if C_CPHA=0, trailing if C_CPHA=1. Shift edge = the other edge.
- Reset (aresetn low, asynchronous):
  - All axis outputs 0, axis_tx_tready 1, IO1_O 0, IO1_T 1.
  - frame_active and all pulse outputs 0.
  - FIFO empty, bit count 0, FSM in IDLE.
  - Reset mid-frame discards the frame; after release the block waits for a fresh SS fall.
- FSM states IDLE and ACTIVE:
  - IDLE -> ACTIVE on synchronised SS fall: bit count = 0, frame_active = 1, IO1_T = 0 next cycle, first_word flag = 1.
  - ACTIVE -> IDLE on synchronised SS rise: IO1_T = 1 next cycle, bit count cleared.
  - If the SS rise finds bit count != 0, the partial RX word is discarded and rx_partial pulses. The TX word already loaded is consumed, not restored.
- Word load:
  - Pop the FIFO head into the TX shift register, or load C_IDLE_WORD and pulse tx_underrun if the FIFO is empty.
  - When: CPHA=0, at SS fall and at the shift edge following each word's last sample. CPHA=1, at the first shift edge of each word.
  - IO1_O is registered and shows the first bit (MSB, or LSB if C_LSB_FIRST) from the cycle after the load.
  - Subsequent shift edges advance one bit. SCK edges while in IDLE are ignored.
- RX path:
  - Each sample edge shifts the synchronised IO0_I into the RX shift register and increments the bit count.
  - On the C_DATA_WIDTH-th sample the bit count wraps to 0 and the word completes.
  - If axis_rx_tvalid is 0, or tvalid and tready are both 1 in that cycle: tdata/tuser are registered and tvalid = 1 on the next cycle (completion latency 1 aclk after the detection cycle); tuser = first_word flag, then first_word flag = 0.
  - Otherwise the word is dropped, the held output is unchanged, and rx_overflow pulses.
  - axis_rx_tvalid deasserts the cycle after a tvalid&tready handshake, unless a new word completes in that same cycle (back-to-back allowed).
- TX FIFO:
  - Push on axis_tx_tvalid & axis_tx_tready.
  - A push into an empty FIFO is poppable from the next cycle.
  - Simultaneous push and pop when full is not possible (tready = 0). When empty, a pop in the same cycle as a push sees empty and underruns.
  - Read/write pointers wrap modulo depth; the extra MSB distinguishes full from empty.
- Simultaneous SS rise and a sample edge in the same cycle: SS rise wins and the sample is ignored.

Test Plan:
- Mode (CPOL0,CPHA1), W=8, FIFO preloaded 0xA5; master sends 0x3C -> rx tdata 0x3C, tuser 1; MISO bits 1,0,1,0,0,1,0,1; FIFO empty afterwards; no pulses.
- Same mode, FIFO empty, C_IDLE_WORD=0xFF; 2-word frame sending 0x11,0x22 -> MISO all 1s; tx_underrun pulses twice; rx words 0x11 (tuser 1) and 0x22 (tuser 0).
- axis_rx_tready held 0 while 2 words (0x55,0x66) arrive -> tdata holds 0x55 with tvalid 1; rx_overflow pulses once; after tready, tvalid drops and 0x66 never appears.
- SS raised after 5 bits -> rx_partial pulses; no tvalid; IO1_T = 1 within 3 aclk. The next full frame 0x81 is received correctly from bit 0.
- Sweep all 4 CPOL/CPHA modes, W=16, C_LSB_FIRST=1, 0x1234 in both directions -> master reads 0x1234 and rx tdata = 0x1234 in every mode.
- Depth 4: push 4 words -> axis_tx_tready 0; one word consumed by a frame -> tready 1. Assert aresetn mid-frame -> all outputs at reset values immediately; FIFO empty (tready 1).
